// File: rtl/fifo_serial_drain.sv
// FIFO read-side drain: pops one word per frame and shifts it out as an async
// serial frame (start, LSB-first data, optional parity, stop). Outputs registered.
module fifo_serial_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, POP, LATCH, START, DATA, PAR, STOP
  } state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_d;
  logic                  baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (enable && !fifo_empty) state_d = POP;
      end
      POP: state_d = LATCH;
      LATCH: begin
        // FIFO read data is valid the cycle after the pop strobe
        shift_d = fifo_data;
        par_d   = (PARITY == 2) ? ~^fifo_data : ^fifo_data;
        baud_d  = '0;
        state_d = START;
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      PAR: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is derived from next-state so tx lands registered on the state change
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PAR:     tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx         <= 1'b1;
      fifo_pop   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx         <= tx_d;
      fifo_pop   <= (state_d == POP);
      busy       <= (state_d != IDLE);
      frame_done <= (state_d == STOP) && (baud_d == BAUD_LAST);
    end
  end

endmodule
